// File: rtl/ila_pkg.sv
// Shared types for the internal logic analyzer and its capture sequencer.
// Contents: analyzer status encoding, host command encoding, sequencer
// state encoding, and small elaboration-time arithmetic helpers.
package ila_pkg;

    typedef enum logic [1:0] {
        STATUS_IDLE      = 2'd0,
        STATUS_ARMED     = 2'd1,
        STATUS_CAPTURING = 2'd2,
        STATUS_DONE      = 2'd3
    } ila_status_t;

    typedef enum logic [1:0] {
        CMD_ARM   = 2'd0,
        CMD_FORCE = 2'd1,
        CMD_DUMP  = 2'd2,
        CMD_ABORT = 2'd3
    } ila_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_DONE_WAIT = 3'd2,
        ST_SYM_RD    = 3'd3,
        ST_SYM_TX    = 3'd4,
        ST_DAT_RD    = 3'd5,
        ST_DAT_TX    = 3'd6,
        ST_DISARM    = 3'd7
    } seq_state_t;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ila_word_serializer.sv
// Parallel-load valid/ready word shifter. A load captures one entry and the
// number of words to emit; words leave least-significant first, and the
// unused upper bits of the final word are zero.
// Ports: clk, rst_n; load, load_data, load_words, load_last (tag the entry's
// final word with tx_last); tx_valid/tx_ready/tx_data/tx_last stream;
// done_c pulses combinationally on the handshake of the entry's final word.
module ila_word_serializer import ila_pkg::*; #(
    parameter  int unsigned IN_WIDTH  = 32,
    parameter  int unsigned OUT_WIDTH = 32,
    localparam int unsigned MAX_WORDS = ceil_div(IN_WIDTH, OUT_WIDTH),
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [IN_WIDTH-1:0]  load_data,
    input  logic [CNT_W-1:0]     load_words,
    input  logic                 load_last,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [OUT_WIDTH-1:0] tx_data,
    output logic                 tx_last,
    output logic                 done_c
);

    localparam int unsigned SH_W = MAX_WORDS * OUT_WIDTH;

    logic [SH_W-1:0]  shreg_q;
    logic [CNT_W-1:0] remaining_q;
    logic             last_q;

    assign tx_data = shreg_q[OUT_WIDTH-1:0];
    assign done_c  = tx_valid && tx_ready && (remaining_q == CNT_W'(1));

    // Shift out one word per handshake; the stream holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            remaining_q <= '0;
            last_q      <= 1'b0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
        end else if (load) begin
            shreg_q     <= SH_W'(load_data);
            remaining_q <= load_words;
            last_q      <= load_last;
            tx_valid    <= (load_words != '0);
            tx_last     <= load_last && (load_words == CNT_W'(1));
        end else if (tx_valid && tx_ready) begin
            shreg_q     <= shreg_q >> OUT_WIDTH;
            remaining_q <= remaining_q - CNT_W'(1);
            tx_valid    <= (remaining_q != CNT_W'(1));
            tx_last     <= last_q && (remaining_q == CNT_W'(2));
        end
    end

endmodule

// File: rtl/ila_capture_sequencer.sv
// Command-driven controller for one internal logic analyzer: arms it, sets
// the trigger offset, issues forced triggers, then after capture completes
// streams the symbol table and sample buffer out as words and disarms.
// Ports: clk, rst_n; cmd_valid/cmd_ready/cmd_op/cmd_offset/cmd_error host
// command interface; trig_armed/trig_force/trig_offset and ila_status to the
// analyzer; symtab_rd_* and data_rd_* registered read ports (data one cycle
// after rd_en); tx_valid/tx_ready/tx_data/tx_last word stream; busy.
// Build option: define ILA_SEQ_TIMEOUT_EN to add a watchdog in ARMED that
// forces a trigger after TIMEOUT_CYCLES and sets the sticky timeout_flag.
module ila_capture_sequencer import ila_pkg::*; #(
    parameter  int unsigned CHANNELS       = 1,
    parameter  int unsigned NAME_LEN       = 16,
    parameter  int unsigned TOTAL_WIDTH    = 32,
    parameter  int unsigned DEPTH          = 1024,
    parameter  int unsigned OUT_WIDTH      = 32,
`ifdef ILA_SEQ_TIMEOUT_EN
    parameter  int unsigned TIMEOUT_CYCLES = 1000000,
`endif
    localparam int unsigned NAME_BITS      = NAME_LEN * 8,
    localparam int unsigned ADDR_BITS      = $clog2(DEPTH),
    localparam int unsigned CHANNEL_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  ila_cmd_t                cmd_op,
    input  logic [ADDR_BITS-1:0]    cmd_offset,
    output logic                    cmd_error,
    output logic                    trig_armed,
    output logic                    trig_force,
    output logic [ADDR_BITS-1:0]    trig_offset,
    input  ila_status_t             ila_status,
    output logic                    symtab_rd_en,
    output logic [CHANNEL_BITS-1:0] symtab_rd_addr,
    input  logic [NAME_BITS-1:0]    symtab_rd_data,
    output logic                    data_rd_en,
    output logic [ADDR_BITS-1:0]    data_rd_addr,
    input  logic [TOTAL_WIDTH-1:0]  data_rd_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [OUT_WIDTH-1:0]    tx_data,
    output logic                    tx_last,
    output logic                    busy
`ifdef ILA_SEQ_TIMEOUT_EN
    ,
    output logic                    timeout_flag
`endif
);

    localparam int unsigned SER_W        = max_u(NAME_BITS, TOTAL_WIDTH);
    localparam int unsigned NAME_WORDS   = ceil_div(NAME_BITS, OUT_WIDTH);
    localparam int unsigned SAMPLE_WORDS = ceil_div(TOTAL_WIDTH, OUT_WIDTH);
    localparam int unsigned CNT_W        = $clog2(ceil_div(SER_W, OUT_WIDTH) + 1);
    localparam int unsigned IDX_W        = CHANNEL_BITS + 1;
    localparam int unsigned DCNT_W       = ADDR_BITS + 1;

    seq_state_t state_q, state_d;

    logic [ADDR_BITS-1:0] offset_d;
    logic                 armed_d, force_d, error_d, ready_d, busy_d;
    logic                 sym_en_d, dat_en_d;
    logic [IDX_W-1:0]     sym_idx_q, sym_idx_d;
    logic [DCNT_W-1:0]    dat_addr_q, dat_addr_d;

    logic                 accept_c;
    logic                 ser_load_c, ser_last_c, ser_done_c;
    logic [SER_W-1:0]     ser_data_c;
    logic [CNT_W-1:0]     ser_words_c;

    assign accept_c       = cmd_valid && cmd_ready;
    assign symtab_rd_addr = sym_idx_q[CHANNEL_BITS-1:0];
    assign data_rd_addr   = dat_addr_q[ADDR_BITS-1:0];

`ifdef ILA_SEQ_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        wdog_fire_c;
    logic        arm_accept_c;

    assign arm_accept_c = (state_q == ST_IDLE) && accept_c && (cmd_op == CMD_ARM);
    assign wdog_fire_c  = (state_q == ST_ARMED) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog counts ARMED cycles; saturates so it fires only once per arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state_q != ST_ARMED) begin
                wdog_q <= '0;
            end else if (wdog_q != 32'(TIMEOUT_CYCLES)) begin
                wdog_q <= wdog_q + 32'd1;
            end
            if (arm_accept_c) begin
                timeout_flag <= 1'b0;
            end else if (wdog_fire_c) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        offset_d    = trig_offset;
        armed_d     = trig_armed;
        force_d     = 1'b0;
        error_d     = 1'b0;
        sym_en_d    = 1'b0;
        dat_en_d    = 1'b0;
        sym_idx_d   = sym_idx_q;
        dat_addr_d  = dat_addr_q;
        ser_load_c  = 1'b0;
        ser_data_c  = '0;
        ser_words_c = '0;
        ser_last_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (cmd_op == CMD_ARM) begin
                        offset_d = cmd_offset;
                        armed_d  = 1'b1;
                        state_d  = ST_ARMED;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                // ABORT wins over a simultaneous capture completion.
                if (accept_c && cmd_op == CMD_ABORT) begin
                    armed_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (accept_c) begin
                        if (cmd_op == CMD_FORCE) force_d = 1'b1;
                        else                     error_d = 1'b1;
                    end
                    if (ila_status == STATUS_DONE) state_d = ST_DONE_WAIT;
                end
            end
            ST_DONE_WAIT: begin
                if (accept_c) begin
                    if (cmd_op == CMD_DUMP) begin
                        sym_idx_d = '0;
                        sym_en_d  = 1'b1;
                        state_d   = ST_SYM_RD;
                    end else if (cmd_op == CMD_ABORT) begin
                        armed_d = 1'b0;
                        state_d = ST_DISARM;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            // rd_en is high on the first RD cycle; read data is valid on the second.
            ST_SYM_RD: begin
                if (!symtab_rd_en) begin
                    ser_load_c  = 1'b1;
                    ser_data_c  = SER_W'(symtab_rd_data);
                    ser_words_c = CNT_W'(NAME_WORDS);
                    state_d     = ST_SYM_TX;
                end
            end
            ST_SYM_TX: begin
                if (ser_done_c) begin
                    if (sym_idx_q == IDX_W'(CHANNELS - 1)) begin
                        dat_addr_d = '0;
                        dat_en_d   = 1'b1;
                        state_d    = ST_DAT_RD;
                    end else begin
                        sym_idx_d = sym_idx_q + IDX_W'(1);
                        sym_en_d  = 1'b1;
                        state_d   = ST_SYM_RD;
                    end
                end
            end
            ST_DAT_RD: begin
                if (!data_rd_en) begin
                    ser_load_c  = 1'b1;
                    ser_data_c  = SER_W'(data_rd_data);
                    ser_words_c = CNT_W'(SAMPLE_WORDS);
                    ser_last_c  = (dat_addr_q == DCNT_W'(DEPTH - 1));
                    state_d     = ST_DAT_TX;
                end
            end
            ST_DAT_TX: begin
                if (ser_done_c) begin
                    if (dat_addr_q == DCNT_W'(DEPTH - 1)) begin
                        armed_d = 1'b0;
                        state_d = ST_DISARM;
                    end else begin
                        dat_addr_d = dat_addr_q + DCNT_W'(1);
                        dat_en_d   = 1'b1;
                        state_d    = ST_DAT_RD;
                    end
                end
            end
            ST_DISARM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef ILA_SEQ_TIMEOUT_EN
        if (wdog_fire_c) force_d = 1'b1;
`endif

        ready_d = (state_d == ST_IDLE) || (state_d == ST_ARMED) || (state_d == ST_DONE_WAIT);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            trig_offset  <= '0;
            trig_armed   <= 1'b0;
            trig_force   <= 1'b0;
            cmd_error    <= 1'b0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            symtab_rd_en <= 1'b0;
            data_rd_en   <= 1'b0;
            sym_idx_q    <= '0;
            dat_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            trig_offset  <= offset_d;
            trig_armed   <= armed_d;
            trig_force   <= force_d;
            cmd_error    <= error_d;
            cmd_ready    <= ready_d;
            busy         <= busy_d;
            symtab_rd_en <= sym_en_d;
            data_rd_en   <= dat_en_d;
            sym_idx_q    <= sym_idx_d;
            dat_addr_q   <= dat_addr_d;
        end
    end

    ila_word_serializer #(
        .IN_WIDTH  (SER_W),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load_c),
        .load_data  (ser_data_c),
        .load_words (ser_words_c),
        .load_last  (ser_last_c),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .done_c     (ser_done_c)
    );

endmodule

// File: tb/tb_ila_capture_sequencer.sv
// Self-checking bench for ila_capture_sequencer with a small analyzer model
// (symbol table and sample memory with one-cycle registered reads).
module tb_ila_capture_sequencer;
    import ila_pkg::*;

    localparam int unsigned CHANNELS     = 2;
    localparam int unsigned NAME_LEN     = 4;
    localparam int unsigned TOTAL_WIDTH  = 40;
    localparam int unsigned DEPTH        = 8;
    localparam int unsigned OUT_WIDTH    = 32;
    localparam int unsigned ADDR_BITS    = 3;
    localparam int unsigned CHANNEL_BITS = 1;
    localparam int unsigned NAME_BITS    = NAME_LEN * 8;
    localparam int          TOTAL_WORDS  = 18;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cmd_valid;
    logic                    cmd_ready;
    ila_cmd_t                cmd_op;
    logic [ADDR_BITS-1:0]    cmd_offset;
    logic                    cmd_error;
    logic                    trig_armed;
    logic                    trig_force;
    logic [ADDR_BITS-1:0]    trig_offset;
    ila_status_t             ila_status;
    logic                    symtab_rd_en;
    logic [CHANNEL_BITS-1:0] symtab_rd_addr;
    logic [NAME_BITS-1:0]    symtab_rd_data;
    logic                    data_rd_en;
    logic [ADDR_BITS-1:0]    data_rd_addr;
    logic [TOTAL_WIDTH-1:0]  data_rd_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [OUT_WIDTH-1:0]    tx_data;
    logic                    tx_last;
    logic                    busy;
`ifdef ILA_SEQ_TIMEOUT_EN
    logic                    timeout_flag;
`endif

    int checks = 0;
    int errors = 0;

    logic [NAME_BITS-1:0]   names   [CHANNELS];
    logic [TOTAL_WIDTH-1:0] samples [DEPTH];

    always #5 clk = ~clk;

    // Analyzer read ports: data appears one cycle after rd_en.
    always @(posedge clk) begin
        if (symtab_rd_en) symtab_rd_data <= names[symtab_rd_addr];
        if (data_rd_en)   data_rd_data   <= samples[data_rd_addr];
    end

    ila_capture_sequencer #(
        .CHANNELS       (CHANNELS),
        .NAME_LEN       (NAME_LEN),
        .TOTAL_WIDTH    (TOTAL_WIDTH),
        .DEPTH          (DEPTH),
        .OUT_WIDTH      (OUT_WIDTH)
`ifdef ILA_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_offset     (cmd_offset),
        .cmd_error      (cmd_error),
        .trig_armed     (trig_armed),
        .trig_force     (trig_force),
        .trig_offset    (trig_offset),
        .ila_status     (ila_status),
        .symtab_rd_en   (symtab_rd_en),
        .symtab_rd_addr (symtab_rd_addr),
        .symtab_rd_data (symtab_rd_data),
        .data_rd_en     (data_rd_en),
        .data_rd_addr   (data_rd_addr),
        .data_rd_data   (data_rd_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_last        (tx_last),
        .busy           (busy)
`ifdef ILA_SEQ_TIMEOUT_EN
        ,
        .timeout_flag   (timeout_flag)
`endif
    );

    // Present one command for one cycle; called and returns on a falling edge.
    task automatic send_cmd(input ila_cmd_t op, input logic [ADDR_BITS-1:0] off);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_offset = off;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, cmd_error, trig_armed, trig_force, symtab_rd_en, data_rd_en,
             tx_valid, tx_last, busy} !== 9'b0 || trig_offset !== 3'd0 || tx_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b err=%b armed=%b force=%b valid=%b last=%b busy=%b off=%0d data=%h want all zero",
                     cmd_ready, cmd_error, trig_armed, trig_force, tx_valid, tx_last, busy, trig_offset, tx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || trig_armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b armed=%b want ready=1 busy=0 armed=0",
                     cmd_ready, busy, trig_armed);
        end
    endtask

    task automatic test_arm_abort();
        send_cmd(CMD_ARM, 3'd3);
        checks++;
        if (trig_armed !== 1'b1 || trig_offset !== 3'd3 || busy !== 1'b1 || cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL arm got armed=%b off=%0d busy=%b err=%b want armed=1 off=3 busy=1 err=0",
                     trig_armed, trig_offset, busy, cmd_error);
        end
        send_cmd(CMD_ABORT, 3'd0);
        checks++;
        if (trig_armed !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_armed got armed=%b busy=%b ready=%b want armed=0 busy=0 ready=1",
                     trig_armed, busy, cmd_ready);
        end
    endtask

    task automatic test_force();
        int pulses;
        send_cmd(CMD_ARM, 3'($urandom_range(7)));
        pulses = 0;
        send_cmd(CMD_FORCE, 3'd0);
        for (int i = 0; i < 4; i++) begin
            if (trig_force === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL force_pulse got %0d cycles high want 1", pulses);
        end
        send_cmd(CMD_ABORT, 3'd0);
    endtask

    task automatic test_errors();
        send_cmd(CMD_DUMP, 3'd0);
        checks++;
        if (cmd_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dump_in_idle got err=%b busy=%b want err=1 busy=0", cmd_error, busy);
        end
        @(negedge clk);
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL error_one_cycle got err=%b want 0", cmd_error);
        end
        send_cmd(CMD_ARM, 3'd5);
        send_cmd(CMD_ARM, 3'd2);
        checks++;
        if (cmd_error !== 1'b1 || trig_offset !== 3'd5 || trig_armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_in_armed got err=%b off=%0d armed=%b want err=1 off=5 armed=1",
                     cmd_error, trig_offset, trig_armed);
        end
        @(negedge clk);
        checks++;
        if (cmd_error !== 1'b0 || trig_armed !== 1'b1) begin
            errors++;
            $display("FAIL arm_in_armed_after got err=%b armed=%b want err=0 armed=1", cmd_error, trig_armed);
        end
        send_cmd(CMD_ABORT, 3'd0);
    endtask

    // Full capture and dump; stop_at >= 0 resets the DUT after that many words.
    task automatic test_dump(input int pct, input int stop_at);
        logic [OUT_WIDTH-1:0] exp_data[$];
        logic                 exp_last[$];
        logic [OUT_WIDTH-1:0] hold_data;
        logic                 hold_last, stalled, rdy;
        logic [ADDR_BITS-1:0] off;
        int                   got, cyc;

        for (int c = 0; c < CHANNELS; c++) names[c] = $urandom;
        for (int s = 0; s < DEPTH; s++) samples[s] = {8'($urandom), 32'($urandom)};
        exp_data.delete();
        exp_last.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            exp_data.push_back(names[c]);
            exp_last.push_back(1'b0);
        end
        for (int s = 0; s < DEPTH; s++) begin
            exp_data.push_back(samples[s][31:0]);
            exp_last.push_back(1'b0);
            exp_data.push_back({24'h0, samples[s][39:32]});
            exp_last.push_back(s == DEPTH - 1);
        end

        off = 3'($urandom_range(7));
        send_cmd(CMD_ARM, off);
        checks++;
        if (trig_armed !== 1'b1 || trig_offset !== off) begin
            errors++;
            $display("FAIL dump_arm got armed=%b off=%0d want armed=1 off=%0d", trig_armed, trig_offset, off);
        end
        ila_status = STATUS_ARMED;
        repeat (3) @(negedge clk);
        ila_status = STATUS_DONE;
        repeat (2) @(negedge clk);
        send_cmd(CMD_DUMP, 3'd0);
        checks++;
        if (cmd_ready !== 1'b0 || cmd_error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dump_start got ready=%b err=%b busy=%b want ready=0 err=0 busy=1",
                     cmd_ready, cmd_error, busy);
        end

        got = 0;
        cyc = 0;
        stalled = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        while (got < TOTAL_WORDS && !(stop_at >= 0 && got >= stop_at) && cyc < 3000) begin
            if (stalled) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== hold_data || tx_last !== hold_last) begin
                    errors++;
                    $display("FAIL stall_hold word=%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                             got, tx_valid, tx_data, tx_last, hold_data, hold_last);
                end
            end
            rdy = ($urandom_range(99) < pct);
            tx_ready = rdy;
            stalled = 1'b0;
            if (tx_valid === 1'b1) begin
                if (rdy) begin
                    checks++;
                    if (tx_data !== exp_data[got] || tx_last !== exp_last[got]) begin
                        errors++;
                        $display("FAIL word_%0d got data=%h last=%b want data=%h last=%b",
                                 got, tx_data, tx_last, exp_data[got], exp_last[got]);
                    end
                    got++;
                end else begin
                    stalled = 1'b1;
                    hold_data = tx_data;
                    hold_last = tx_last;
                end
            end
            @(negedge clk);
            cyc++;
        end

        if (stop_at >= 0) begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if ({tx_valid, tx_last, trig_armed, trig_force, busy, cmd_ready, cmd_error,
                 symtab_rd_en, data_rd_en} !== 9'b0) begin
                errors++;
                $display("FAIL mid_dump_reset got valid=%b last=%b armed=%b busy=%b ready=%b rd_en=%b want all zero",
                         tx_valid, tx_last, trig_armed, busy, cmd_ready, data_rd_en);
            end
            checks++;
            if (tx_data !== 32'd0 || trig_offset !== 3'd0 || data_rd_addr !== 3'd0) begin
                errors++;
                $display("FAIL mid_dump_reset_regs got data=%h off=%0d addr=%0d want 0 0 0",
                         tx_data, trig_offset, data_rd_addr);
            end
            @(negedge clk);
            rst_n = 1'b1;
            tx_ready = 1'b0;
            ila_status = STATUS_IDLE;
            @(negedge clk);
        end else begin
            checks++;
            if (got !== TOTAL_WORDS) begin
                errors++;
                $display("FAIL word_count got %0d want %0d after %0d cycles", got, TOTAL_WORDS, cyc);
            end
            tx_ready = 1'b0;
            checks++;
            if (trig_armed !== 1'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_dump_disarm got armed=%b valid=%b want armed=0 valid=0", trig_armed, tx_valid);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_dump_idle got busy=%b ready=%b valid=%b want busy=0 ready=1 valid=0",
                         busy, cmd_ready, tx_valid);
            end
            ila_status = STATUS_IDLE;
        end
    endtask

`ifdef ILA_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        send_cmd(CMD_ARM, 3'd1);
        ila_status = STATUS_ARMED;
        n = 0;
        while (trig_force !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 50) begin
            errors++;
            $display("FAIL timeout_cycle got %0d want 50", n);
        end
        checks++;
        if (timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag_set got %b want 1", timeout_flag);
        end
        send_cmd(CMD_ABORT, 3'd0);
        checks++;
        if (timeout_flag !== 1'b1 || trig_force !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag_sticky got flag=%b force=%b want flag=1 force=0", timeout_flag, trig_force);
        end
        ila_status = STATUS_IDLE;
        send_cmd(CMD_ARM, 3'd0);
        checks++;
        if (timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag_clear got %b want 0", timeout_flag);
        end
        send_cmd(CMD_ABORT, 3'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_watchdog bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = CMD_ARM;
        cmd_offset = '0;
        ila_status = STATUS_IDLE;
        tx_ready   = 1'b0;
        test_reset();
        test_arm_abort();
        test_force();
        test_errors();
        test_dump(100, -1);
        test_dump(30, -1);
        test_dump(100, 8);
        test_dump(100, -1);
`ifdef ILA_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
